// File: rtl/wb_arbiter_2m_pkg.sv
// rtl/wb_arbiter_2m_pkg.sv - shared types for the two-master wishbone arbiter
package wb_arbiter_2m_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_GNT0 = 2'd1,
    ST_GNT1 = 2'd2
  } arb_state_t;

  typedef logic mst_idx_t;

  localparam mst_idx_t MST0 = 1'b0;
  localparam mst_idx_t MST1 = 1'b1;

  function automatic arb_state_t gnt_state(input mst_idx_t m);
    return (m == MST1) ? ST_GNT1 : ST_GNT0;
  endfunction

endpackage

// File: rtl/wb_arbiter_2m.sv
// rtl/wb_arbiter_2m.sv - round-robin two-master wishbone classic arbiter with stall watchdog
module wb_arbiter_2m
  import wb_arbiter_2m_pkg::*;
#(
  parameter int DATAW   = 32,
  parameter int ADDRW   = 20,
  parameter int TIMEOUT = 255
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [ADDRW-1:0] wbm0_adr_i,
  input  logic [DATAW-1:0] wbm0_dat_i,
  output logic [DATAW-1:0] wbm0_dat_o,
  input  logic             wbm0_we_i,
  input  logic             wbm0_stb_i,
  input  logic             wbm0_cyc_i,
  output logic             wbm0_ack_o,
  output logic             wbm0_err_o,
  input  logic [ADDRW-1:0] wbm1_adr_i,
  input  logic [DATAW-1:0] wbm1_dat_i,
  output logic [DATAW-1:0] wbm1_dat_o,
  input  logic             wbm1_we_i,
  input  logic             wbm1_stb_i,
  input  logic             wbm1_cyc_i,
  output logic             wbm1_ack_o,
  output logic             wbm1_err_o,
  output logic [ADDRW-1:0] wbs_adr_o,
  output logic [DATAW-1:0] wbs_dat_o,
  input  logic [DATAW-1:0] wbs_dat_i,
  output logic             wbs_we_o,
  output logic             wbs_stb_o,
  output logic             wbs_cyc_o,
  input  logic             wbs_ack_i
);

  arb_state_t r_state;
  mst_idx_t   r_last_gnt;

  logic w_gnt0;
  logic w_gnt1;
  logic w_hold;
  logic w_timeout;

  // r_last_gnt starts at MST1 so master 0 wins the first tie.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= ST_IDLE;
      r_last_gnt <= MST1;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (wbm0_cyc_i && (!wbm1_cyc_i || (r_last_gnt == MST1))) begin
            r_state    <= gnt_state(MST0);
            r_last_gnt <= MST0;
          end else if (wbm1_cyc_i) begin
            r_state    <= gnt_state(MST1);
            r_last_gnt <= MST1;
          end
        end
        ST_GNT0: begin
          if (!wbm0_cyc_i) begin
            if (wbm1_cyc_i) begin
              r_state    <= gnt_state(MST1);
              r_last_gnt <= MST1;
            end else begin
              r_state <= ST_IDLE;
            end
          end
        end
        ST_GNT1: begin
          if (!wbm1_cyc_i) begin
            if (wbm0_cyc_i) begin
              r_state    <= gnt_state(MST0);
              r_last_gnt <= MST0;
            end else begin
              r_state <= ST_IDLE;
            end
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign w_gnt0 = (r_state == ST_GNT0);
  assign w_gnt1 = (r_state == ST_GNT1);
  assign w_hold = (w_gnt0 && wbm0_cyc_i) || (w_gnt1 && wbm1_cyc_i);

  always_comb begin
    wbs_adr_o  = '0;
    wbs_dat_o  = '0;
    wbs_we_o   = 1'b0;
    wbs_stb_o  = 1'b0;
    wbs_cyc_o  = 1'b0;
    wbm0_dat_o = '0;
    wbm0_ack_o = 1'b0;
    wbm0_err_o = 1'b0;
    wbm1_dat_o = '0;
    wbm1_ack_o = 1'b0;
    wbm1_err_o = 1'b0;
    if (w_gnt0) begin
      wbs_adr_o  = wbm0_adr_i;
      wbs_dat_o  = wbm0_dat_i;
      wbs_we_o   = wbm0_we_i;
      wbs_stb_o  = wbm0_stb_i;
      wbs_cyc_o  = wbm0_cyc_i;
      wbm0_dat_o = wbs_dat_i;
      wbm0_ack_o = wbs_ack_i;
      wbm0_err_o = w_timeout;
    end else if (w_gnt1) begin
      wbs_adr_o  = wbm1_adr_i;
      wbs_dat_o  = wbm1_dat_i;
      wbs_we_o   = wbm1_we_i;
      wbs_stb_o  = wbm1_stb_i;
      wbs_cyc_o  = wbm1_cyc_i;
      wbm1_dat_o = wbs_dat_i;
      wbm1_ack_o = wbs_ack_i;
      wbm1_err_o = w_timeout;
    end
  end

  generate
    if (TIMEOUT > 0) begin : g_wd
      localparam int CNTW = $clog2(TIMEOUT + 1);
      localparam logic [CNTW-1:0] CNT_MAX = CNTW'(TIMEOUT);

      logic [CNTW-1:0] r_wd_cnt;

      // Losing the grant or finishing a beat restarts the stall count.
      always_ff @(posedge clk) begin
        if (rst || !w_hold || !wbs_stb_o || wbs_ack_i || (r_wd_cnt == CNT_MAX)) begin
          r_wd_cnt <= '0;
        end else begin
          r_wd_cnt <= r_wd_cnt + 1'b1;
        end
      end

      assign w_timeout = wbs_stb_o && !wbs_ack_i && (r_wd_cnt == CNT_MAX);
    end else begin : g_no_wd
      assign w_timeout = 1'b0;
    end
  endgenerate

endmodule

// File: tb/tb_wb_arbiter_2m.sv
// tb/tb_wb_arbiter_2m.sv - directed self-checking bench for wb_arbiter_2m
module tb_wb_arbiter_2m;

  localparam int DATAW = 32;
  localparam int ADDRW = 20;

  logic             clk;
  logic             rst;
  logic [ADDRW-1:0] wbm0_adr_i, wbm1_adr_i;
  logic [DATAW-1:0] wbm0_dat_i, wbm1_dat_i;
  logic [DATAW-1:0] wbm0_dat_o, wbm1_dat_o;
  logic             wbm0_we_i, wbm1_we_i;
  logic             wbm0_stb_i, wbm1_stb_i;
  logic             wbm0_cyc_i, wbm1_cyc_i;
  logic             wbm0_ack_o, wbm1_ack_o;
  logic             wbm0_err_o, wbm1_err_o;
  logic [ADDRW-1:0] wbs_adr_o;
  logic [DATAW-1:0] wbs_dat_o;
  logic [DATAW-1:0] wbs_dat_i;
  logic             wbs_we_o, wbs_stb_o, wbs_cyc_o;
  logic             wbs_ack_i;

  int n_vec;
  int n_err;

  wb_arbiter_2m #(.DATAW(DATAW), .ADDRW(ADDRW), .TIMEOUT(8)) dut (
    .clk        (clk),
    .rst        (rst),
    .wbm0_adr_i (wbm0_adr_i),
    .wbm0_dat_i (wbm0_dat_i),
    .wbm0_dat_o (wbm0_dat_o),
    .wbm0_we_i  (wbm0_we_i),
    .wbm0_stb_i (wbm0_stb_i),
    .wbm0_cyc_i (wbm0_cyc_i),
    .wbm0_ack_o (wbm0_ack_o),
    .wbm0_err_o (wbm0_err_o),
    .wbm1_adr_i (wbm1_adr_i),
    .wbm1_dat_i (wbm1_dat_i),
    .wbm1_dat_o (wbm1_dat_o),
    .wbm1_we_i  (wbm1_we_i),
    .wbm1_stb_i (wbm1_stb_i),
    .wbm1_cyc_i (wbm1_cyc_i),
    .wbm1_ack_o (wbm1_ack_o),
    .wbm1_err_o (wbm1_err_o),
    .wbs_adr_o  (wbs_adr_o),
    .wbs_dat_o  (wbs_dat_o),
    .wbs_dat_i  (wbs_dat_i),
    .wbs_we_o   (wbs_we_o),
    .wbs_stb_o  (wbs_stb_o),
    .wbs_cyc_o  (wbs_cyc_o),
    .wbs_ack_i  (wbs_ack_i)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  task automatic check_quiet(input string tag);
    check_eq({tag, "_cyc"}, 64'(wbs_cyc_o), 64'd0);
    check_eq({tag, "_stb"}, 64'(wbs_stb_o), 64'd0);
    check_eq({tag, "_adr"}, 64'(wbs_adr_o), 64'd0);
    check_eq({tag, "_ack0"}, 64'(wbm0_ack_o), 64'd0);
    check_eq({tag, "_ack1"}, 64'(wbm1_ack_o), 64'd0);
    check_eq({tag, "_err0"}, 64'(wbm0_err_o), 64'd0);
    check_eq({tag, "_err1"}, 64'(wbm1_err_o), 64'd0);
    check_eq({tag, "_dat0"}, 64'(wbm0_dat_o), 64'd0);
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    rst = 1'b1;
    wbm0_adr_i = '0; wbm0_dat_i = '0; wbm0_we_i = 1'b0; wbm0_stb_i = 1'b0; wbm0_cyc_i = 1'b0;
    wbm1_adr_i = '0; wbm1_dat_i = '0; wbm1_we_i = 1'b0; wbm1_stb_i = 1'b0; wbm1_cyc_i = 1'b0;
    wbs_dat_i = 32'h5A5A_0001;
    wbs_ack_i = 1'b0;

    tick(); tick(); smp();
    check_quiet("rst");
    tick(); rst = 1'b0; smp();
    check_quiet("idle");

    // master 0 write, slave acks on the third grant cycle
    tick();
    wbm0_cyc_i = 1'b1; wbm0_stb_i = 1'b1; wbm0_we_i = 1'b1;
    wbm0_adr_i = 20'hE0004; wbm0_dat_i = 32'h1234_5678;
    smp();
    check_eq("arb_latency_cyc", 64'(wbs_cyc_o), 64'd0);
    tick(); smp();
    check_eq("wr_adr", 64'(wbs_adr_o), 64'hE0004);
    check_eq("wr_dat", 64'(wbs_dat_o), 64'h1234_5678);
    check_eq("wr_we", 64'(wbs_we_o), 64'd1);
    check_eq("wr_stb", 64'(wbs_stb_o), 64'd1);
    check_eq("wr_cyc", 64'(wbs_cyc_o), 64'd1);
    check_eq("wr_ack_early", 64'(wbm0_ack_o), 64'd0);
    tick(); smp();
    check_eq("wr_ack_wait", 64'(wbm0_ack_o), 64'd0);
    tick(); wbs_ack_i = 1'b1; smp();
    check_eq("wr_ack", 64'(wbm0_ack_o), 64'd1);
    check_eq("wr_ack_other", 64'(wbm1_ack_o), 64'd0);
    tick(); wbs_ack_i = 1'b0; wbm0_cyc_i = 1'b0; wbm0_stb_i = 1'b0; wbm0_we_i = 1'b0; smp();
    check_eq("wr_ack_once", 64'(wbm0_ack_o), 64'd0);
    check_eq("wr_release_cyc", 64'(wbs_cyc_o), 64'd0);
    tick(); smp();

    // reset, then both request together: master 0 first, direct handoff to master 1
    tick(); rst = 1'b1;
    tick(); rst = 1'b0;
    wbm0_adr_i = 20'h00020; wbm1_adr_i = 20'h00010;
    wbm0_cyc_i = 1'b1; wbm0_stb_i = 1'b1; wbm1_cyc_i = 1'b1; wbm1_stb_i = 1'b1;
    wbs_dat_i = 32'hCAFE_F00D;
    smp();
    check_eq("tie_idle_cyc", 64'(wbs_cyc_o), 64'd0);
    tick(); wbs_ack_i = 1'b1; smp();
    check_eq("tie_first_adr", 64'(wbs_adr_o), 64'h00020);
    check_eq("tie_ack0", 64'(wbm0_ack_o), 64'd1);
    check_eq("tie_ack1", 64'(wbm1_ack_o), 64'd0);
    check_eq("tie_dat1_zero", 64'(wbm1_dat_o), 64'd0);
    tick(); wbs_ack_i = 1'b0; wbm0_cyc_i = 1'b0; wbm0_stb_i = 1'b0; smp();
    check_eq("handoff_drop_cyc", 64'(wbs_cyc_o), 64'd0);
    tick(); smp();
    check_eq("handoff_adr", 64'(wbs_adr_o), 64'h00010);
    check_eq("handoff_cyc", 64'(wbs_cyc_o), 64'd1);
    check_eq("rd_dat0_zero_a", 64'(wbm0_dat_o), 64'd0);
    check_eq("rd_ack1_early", 64'(wbm1_ack_o), 64'd0);
    tick(); wbs_ack_i = 1'b1; smp();
    check_eq("rd_dat1", 64'(wbm1_dat_o), 64'hCAFE_F00D);
    check_eq("rd_ack1", 64'(wbm1_ack_o), 64'd1);
    check_eq("rd_dat0_zero_b", 64'(wbm0_dat_o), 64'd0);
    check_eq("rd_ack0_zero", 64'(wbm0_ack_o), 64'd0);
    tick(); wbs_ack_i = 1'b0; wbm1_cyc_i = 1'b0; wbm1_stb_i = 1'b0; smp();
    tick(); smp();
    check_eq("rd_back_idle", 64'(wbs_cyc_o), 64'd0);

    // continuous contention: grants alternate 0,1,0,1
    wbm0_adr_i = 20'h00100; wbm1_adr_i = 20'h00200;
    tick(); wbm0_cyc_i = 1'b1; wbm0_stb_i = 1'b1; wbm1_cyc_i = 1'b1; wbm1_stb_i = 1'b1; smp();
    tick();
    for (int i = 0; i < 4; i++) begin
      wbs_ack_i = 1'b1;
      smp();
      check_eq($sformatf("alt_adr_%0d", i), 64'(wbs_adr_o), (i % 2 == 0) ? 64'h00100 : 64'h00200);
      check_eq($sformatf("alt_ack_%0d", i), (i % 2 == 0) ? 64'(wbm0_ack_o) : 64'(wbm1_ack_o), 64'd1);
      tick();
      wbs_ack_i = 1'b0;
      if (i % 2 == 0) begin
        wbm0_cyc_i = 1'b0; wbm0_stb_i = 1'b0;
      end else begin
        wbm1_cyc_i = 1'b0; wbm1_stb_i = 1'b0;
      end
      smp();
      tick();
      wbm0_cyc_i = 1'b1; wbm0_stb_i = 1'b1; wbm1_cyc_i = 1'b1; wbm1_stb_i = 1'b1;
    end

    // master 0 holds cyc over three beats with stb gaps while master 1 waits
    for (int b = 0; b < 3; b++) begin
      wbs_ack_i = 1'b1;
      smp();
      check_eq($sformatf("hold_adr_%0d", b), 64'(wbs_adr_o), 64'h00100);
      check_eq($sformatf("hold_ack_%0d", b), 64'(wbm0_ack_o), 64'd1);
      tick();
      wbs_ack_i = 1'b0; wbm0_stb_i = 1'b0;
      smp();
      check_eq($sformatf("gap_stb_%0d", b), 64'(wbs_stb_o), 64'd0);
      check_eq($sformatf("gap_adr_%0d", b), 64'(wbs_adr_o), 64'h00100);
      tick();
      wbm0_stb_i = 1'b1;
    end
    wbm0_cyc_i = 1'b0; wbm0_stb_i = 1'b0;
    smp();
    tick(); smp();
    check_eq("hold_handoff_adr", 64'(wbs_adr_o), 64'h00200);
    tick(); wbm1_cyc_i = 1'b0; wbm1_stb_i = 1'b0; smp();
    tick(); smp();

    // watchdog: slave never acks, err pulses once on stall cycle 8
    tick(); wbm0_cyc_i = 1'b1; wbm0_stb_i = 1'b1; smp();
    tick();
    for (int k = 0; k < 10; k++) begin
      smp();
      check_eq($sformatf("wd_err_%0d", k), 64'(wbm0_err_o), (k == 8) ? 64'd1 : 64'd0);
      check_eq($sformatf("wd_noack_%0d", k), 64'(wbm0_ack_o), 64'd0);
      tick();
    end
    wbm0_cyc_i = 1'b0; wbm0_stb_i = 1'b0; smp();
    tick(); smp();

    // late ack on the timeout cycle: ack wins
    tick(); wbm0_cyc_i = 1'b1; wbm0_stb_i = 1'b1; smp();
    tick();
    for (int k = 0; k < 9; k++) begin
      if (k == 8) wbs_ack_i = 1'b1;
      smp();
      check_eq($sformatf("late_err_%0d", k), 64'(wbm0_err_o), 64'd0);
      check_eq($sformatf("late_ack_%0d", k), 64'(wbm0_ack_o), (k == 8) ? 64'd1 : 64'd0);
      tick();
    end
    wbs_ack_i = 1'b0; wbm0_cyc_i = 1'b0; wbm0_stb_i = 1'b0; smp();
    tick(); smp();

    // reset in the middle of a master 1 cycle
    tick(); wbm1_cyc_i = 1'b1; wbm1_stb_i = 1'b1; smp();
    tick(); smp();
    check_eq("mid_gnt1_cyc", 64'(wbs_cyc_o), 64'd1);
    check_eq("mid_gnt1_adr", 64'(wbs_adr_o), 64'h00200);
    tick(); rst = 1'b1; smp();
    check_eq("mid_rst_sync", 64'(wbs_cyc_o), 64'd1);
    tick(); rst = 1'b0; smp();
    check_quiet("mid_rst");
    tick(); smp();
    check_eq("regrant_cyc", 64'(wbs_cyc_o), 64'd1);
    check_eq("regrant_adr", 64'(wbs_adr_o), 64'h00200);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
